// File: rtl/lockstep_run_monitor_pkg.sv
// Shared state encodings and FIFO sizing helpers for the lockstep run monitor.
package lockstep_pkg;

    localparam int unsigned ST_W = 3;

    typedef logic [ST_W-1:0] mon_state_t;

    localparam mon_state_t ST_IDLE     = 3'd0;
    localparam mon_state_t ST_RUN      = 3'd1;
    localparam mon_state_t ST_DRAIN    = 3'd2;
    localparam mon_state_t ST_DONE     = 3'd3;
    localparam mon_state_t ST_TIMEOUT  = 3'd4;
    localparam mon_state_t ST_MISMATCH = 3'd5;
    localparam mon_state_t ST_OVERFLOW = 3'd6;

    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

    // One extra pointer bit beyond the index distinguishes full from empty.
    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned DEFAULT_FIFO_PTR_W = fifo_ptr_w(DEFAULT_FIFO_DEPTH);

    function automatic logic is_terminal(input mon_state_t st);
        return (st == ST_DONE) || (st == ST_TIMEOUT) ||
               (st == ST_MISMATCH) || (st == ST_OVERFLOW);
    endfunction

endpackage

// File: rtl/lockstep_run_monitor_if.sv
// Control, commit-trace and status bundle between the bench and the run monitor.
interface lockstep_run_monitor_if #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned TRACE_W   = 32,
    parameter int unsigned CNT_W     = 16
);
    logic                           start;
    logic [NUM_CORES-1:0]           stop_i;
    logic [NUM_CORES-1:0]           commit_valid_i;
    logic [NUM_CORES*TRACE_W-1:0]   commit_data_i;

    logic                           busy;
    logic                           done;
    logic                           timeout;
    logic                           mismatch;
    logic                           overflow;
    logic [NUM_CORES-1:0]           mismatch_mask;
    logic [CNT_W-1:0]               cycle_count;
    logic [CNT_W-1:0]               compare_count;
    logic                           finish;

    modport master (
        output start, stop_i, commit_valid_i, commit_data_i,
        input  busy, done, timeout, mismatch, overflow,
               mismatch_mask, cycle_count, compare_count, finish
    );

    modport slave (
        input  start, stop_i, commit_valid_i, commit_data_i,
        output busy, done, timeout, mismatch, overflow,
               mismatch_mask, cycle_count, compare_count, finish
    );

endinterface

// File: rtl/lockstep_run_monitor_trace_fifo.sv
// Per-core commit FIFO; push/pop are guarded so an illegal request never corrupts pointers.
module trace_fifo
    import lockstep_pkg::*;
#(
    parameter int unsigned TRACE_W    = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic [TRACE_W-1:0] din,
    output logic [TRACE_W-1:0] dout,
    output logic               empty,
    output logic               full
);

    localparam int unsigned PTR_W = fifo_ptr_w(FIFO_DEPTH);
    localparam int unsigned IDX_W = PTR_W - 1;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TRACE_W-1:0] mem_q [FIFO_DEPTH];
    logic [TRACE_W-1:0] mem_d [FIFO_DEPTH];
    logic               do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign dout  = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = din;
        end
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/lockstep_run_monitor.sv
// Lockstep run monitor: buffers per-core commit traces, compares heads against core 0,
// and bounds the run with a watchdog; status is decoded from the registered state.
module lockstep_run_monitor
    import lockstep_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 2,
    parameter int unsigned TRACE_W    = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_CYCLES = 500,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned STOP_ALL   = 0
) (
    input logic                    clk,
    input logic                    reset,
    lockstep_run_monitor_if.slave  mon
);

    mon_state_t           state_q, state_d;
    logic [NUM_CORES-1:0] sticky_q, sticky_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]     cyc_q, cyc_d;
    logic [CNT_W-1:0]     cmp_q, cmp_d;
    logic                 finish_q, finish_d;

    logic                 run, clear, fire, stop_cond;
    logic [NUM_CORES-1:0] push, empty, full, diff, ovf;
    logic [TRACE_W-1:0]   head [NUM_CORES];

    assign run   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign clear = mon.start && !run;
    assign push  = run ? mon.commit_valid_i : '0;
    assign fire  = run && (empty == '0);

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_fifo
        trace_fifo #(
            .TRACE_W    (TRACE_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .push  (push[gi]),
            .pop   (fire),
            .din   (mon.commit_data_i[gi*TRACE_W +: TRACE_W]),
            .dout  (head[gi]),
            .empty (empty[gi]),
            .full  (full[gi])
        );
    end

    always_comb begin
        diff = '0;
        ovf  = '0;
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            diff[c] = fire && (head[c] != head[0]);
            // A full FIFO may still accept a push when the group pops on the same edge.
            ovf[c]  = push[c] && full[c] && !fire;
        end
        if (STOP_ALL != 0) begin
            stop_cond = &(sticky_q | mon.stop_i);
        end else begin
            stop_cond = |mon.stop_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        sticky_d = sticky_q;
        mask_d   = mask_q;
        cyc_d    = cyc_q;
        cmp_d    = cmp_q;
        finish_d = 1'b0;

        if (!run) begin
            if (mon.start) begin
                state_d  = ST_RUN;
                sticky_d = '0;
                mask_d   = '0;
                cyc_d    = '0;
                cmp_d    = '0;
            end
        end else begin
            sticky_d = sticky_q | mon.stop_i;
            if (fire && (diff == '0)) begin
                cmp_d = cmp_q + CNT_W'(1);
            end

            if (ovf != '0) begin
                state_d = ST_OVERFLOW;
                mask_d  = ovf;
            end else if (diff != '0) begin
                state_d = ST_MISMATCH;
                mask_d  = diff;
            end else if ((state_q == ST_DRAIN) && !fire && (empty != '1)) begin
                state_d = ST_MISMATCH;
                mask_d  = ~empty;
            end else if (cyc_q == CNT_W'(MAX_CYCLES - 1)) begin
                state_d = ST_TIMEOUT;
            end else if ((state_q == ST_DRAIN) && !fire) begin
                state_d = ST_DONE;
            end else if ((state_q == ST_RUN) && stop_cond) begin
                state_d = ST_DRAIN;
            end

            // The exit edge is not counted, so cycle_count freezes at the watchdog limit.
            if (is_terminal(state_d)) begin
                finish_d = 1'b1;
            end else if (cyc_q != '1) begin
                cyc_d = cyc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sticky_q <= '0;
            mask_q   <= '0;
            cyc_q    <= '0;
            cmp_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sticky_q <= sticky_d;
            mask_q   <= mask_d;
            cyc_q    <= cyc_d;
            cmp_q    <= cmp_d;
            finish_q <= finish_d;
        end
    end

    assign mon.busy          = run;
    assign mon.done          = (state_q == ST_DONE);
    assign mon.timeout       = (state_q == ST_TIMEOUT);
    assign mon.mismatch      = (state_q == ST_MISMATCH);
    assign mon.overflow      = (state_q == ST_OVERFLOW);
    assign mon.mismatch_mask = mask_q;
    assign mon.cycle_count   = cyc_q;
    assign mon.compare_count = cmp_q;
    assign mon.finish        = finish_q;

endmodule

// File: tb/tb_lockstep_run_monitor.sv
// Directed bench: a per-cycle vector table for the clean lockstep run, plus hand sequences
// for divergence, overflow, count mismatch, watchdog, STOP_ALL and mid-run reset.
module tb_lockstep_run_monitor;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    lockstep_run_monitor_if #(.NUM_CORES(2), .TRACE_W(32), .CNT_W(16)) if0 ();
    lockstep_run_monitor_if #(.NUM_CORES(2), .TRACE_W(32), .CNT_W(16)) if1 ();

    lockstep_run_monitor #(
        .NUM_CORES(2), .TRACE_W(32), .FIFO_DEPTH(4),
        .MAX_CYCLES(500), .CNT_W(16), .STOP_ALL(0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .mon   (if0)
    );

    lockstep_run_monitor #(
        .NUM_CORES(2), .TRACE_W(32), .FIFO_DEPTH(4),
        .MAX_CYCLES(20), .CNT_W(16), .STOP_ALL(1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .mon   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [1:0]  stop;
        logic [1:0]  valid;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        busy;
        logic        done;
        logic        fin;
        logic [15:0] cyc;
        logic [15:0] cmp;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic st, input logic [1:0] sp, input logic [1:0] v,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic bz, input logic dn, input logic fn,
                                input logic [15:0] cy, input logic [15:0] cm);
        vec_t r;
        r.start = st; r.stop = sp; r.valid = v; r.d0 = a; r.d1 = b;
        r.busy = bz; r.done = dn; r.fin = fn; r.cyc = cy; r.cmp = cm;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive0(input logic st, input logic [1:0] sp, input logic [1:0] v,
                          input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if0.start          = st;
        if0.stop_i         = sp;
        if0.commit_valid_i = v;
        if0.commit_data_i  = {b, a};
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic st, input logic [1:0] sp);
        @(negedge clk);
        if1.start          = st;
        if1.stop_i         = sp;
        if1.commit_valid_i = 2'b00;
        if1.commit_data_i  = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        if0.start = 1'b0; if0.stop_i = '0; if0.commit_valid_i = '0; if0.commit_data_i = '0;
        if1.start = 1'b0; if1.stop_i = '0; if1.commit_valid_i = '0; if1.commit_data_i = '0;

        // Clean run: core 1 trails core 0 by two cycles, stop follows core 0's last commit.
        tbl[0]  = mk(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0,  16'd0);
        tbl[1]  = mk(1'b0, 2'b00, 2'b01, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0, 16'd1,  16'd0);
        tbl[2]  = mk(1'b0, 2'b00, 2'b01, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0, 16'd2,  16'd0);
        tbl[3]  = mk(1'b0, 2'b00, 2'b11, 32'h3, 32'h1, 1'b1, 1'b0, 1'b0, 16'd3,  16'd0);
        tbl[4]  = mk(1'b0, 2'b00, 2'b11, 32'h4, 32'h2, 1'b1, 1'b0, 1'b0, 16'd4,  16'd1);
        tbl[5]  = mk(1'b0, 2'b00, 2'b11, 32'h5, 32'h3, 1'b1, 1'b0, 1'b0, 16'd5,  16'd2);
        tbl[6]  = mk(1'b0, 2'b00, 2'b11, 32'h6, 32'h4, 1'b1, 1'b0, 1'b0, 16'd6,  16'd3);
        tbl[7]  = mk(1'b0, 2'b00, 2'b11, 32'h7, 32'h5, 1'b1, 1'b0, 1'b0, 16'd7,  16'd4);
        tbl[8]  = mk(1'b0, 2'b00, 2'b11, 32'h8, 32'h6, 1'b1, 1'b0, 1'b0, 16'd8,  16'd5);
        tbl[9]  = mk(1'b0, 2'b01, 2'b10, 32'h0, 32'h7, 1'b1, 1'b0, 1'b0, 16'd9,  16'd6);
        tbl[10] = mk(1'b0, 2'b01, 2'b10, 32'h0, 32'h8, 1'b1, 1'b0, 1'b0, 16'd10, 16'd7);
        tbl[11] = mk(1'b0, 2'b01, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd11, 16'd8);
        tbl[12] = mk(1'b0, 2'b01, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 16'd11, 16'd8);
        tbl[13] = mk(1'b0, 2'b01, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd11, 16'd8);
        tbl[14] = mk(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd11, 16'd8);
        tbl[15] = mk(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0,  16'd0);

        repeat (2) @(negedge clk);
        chk("rst.busy",     {31'b0, if0.busy}, 32'd0);
        chk("rst.done",     {31'b0, if0.done}, 32'd0);
        chk("rst.timeout",  {31'b0, if1.timeout}, 32'd0);
        chk("rst.overflow", {31'b0, if0.overflow}, 32'd0);
        chk("rst.mask",     {30'b0, if0.mismatch_mask}, 32'd0);
        chk("rst.cyc",      {16'b0, if0.cycle_count}, 32'd0);
        chk("rst.finish",   {31'b0, if0.finish}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive0(tbl[i].start, tbl[i].stop, tbl[i].valid, tbl[i].d0, tbl[i].d1);
            chk($sformatf("tbl%0d.busy", i),     {31'b0, if0.busy},     {31'b0, tbl[i].busy});
            chk($sformatf("tbl%0d.done", i),     {31'b0, if0.done},     {31'b0, tbl[i].done});
            chk($sformatf("tbl%0d.finish", i),   {31'b0, if0.finish},   {31'b0, tbl[i].fin});
            chk($sformatf("tbl%0d.cyc", i),      {16'b0, if0.cycle_count},   {16'b0, tbl[i].cyc});
            chk($sformatf("tbl%0d.cmp", i),      {16'b0, if0.compare_count}, {16'b0, tbl[i].cmp});
            chk($sformatf("tbl%0d.mismatch", i), {31'b0, if0.mismatch}, 32'd0);
        end

        // Divergence: third commit of core 1 differs.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        drive0(1'b1, 2'b00, 2'b00, 32'h0, 32'h0);
        drive0(1'b0, 2'b00, 2'b11, 32'h1, 32'h1);
        drive0(1'b0, 2'b00, 2'b11, 32'h2, 32'h2);
        drive0(1'b0, 2'b00, 2'b11, 32'h3, 32'hDEAD);
        chk("div.pre_mismatch", {31'b0, if0.mismatch}, 32'd0);
        chk("div.pre_cmp",      {16'b0, if0.compare_count}, 32'd2);
        drive0(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        chk("div.mismatch", {31'b0, if0.mismatch}, 32'd1);
        chk("div.mask",     {30'b0, if0.mismatch_mask}, 32'd2);
        chk("div.cmp",      {16'b0, if0.compare_count}, 32'd2);
        chk("div.finish",   {31'b0, if0.finish}, 32'd1);
        chk("div.busy",     {31'b0, if0.busy}, 32'd0);
        drive0(1'b0, 2'b00, 2'b11, 32'h9, 32'h9);
        chk("div.finish_once", {31'b0, if0.finish}, 32'd0);
        chk("div.hold",        {31'b0, if0.mismatch}, 32'd1);

        // Overflow: re-armed from a terminal state, core 1 silent.
        drive0(1'b1, 2'b00, 2'b00, 32'h0, 32'h0);
        chk("ovf.rearm_busy", {31'b0, if0.busy}, 32'd1);
        chk("ovf.rearm_mask", {30'b0, if0.mismatch_mask}, 32'd0);
        chk("ovf.rearm_mm",   {31'b0, if0.mismatch}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            drive0(1'b0, 2'b00, 2'b01, k, 32'h0);
        end
        chk("ovf.pre", {31'b0, if0.overflow}, 32'd0);
        drive0(1'b0, 2'b00, 2'b01, 32'h5, 32'h0);
        chk("ovf.flag",   {31'b0, if0.overflow}, 32'd1);
        chk("ovf.mask",   {30'b0, if0.mismatch_mask}, 32'd1);
        chk("ovf.finish", {31'b0, if0.finish}, 32'd1);

        // Commit-count mismatch discovered in DRAIN.
        drive0(1'b1, 2'b00, 2'b00, 32'h0, 32'h0);
        drive0(1'b0, 2'b00, 2'b11, 32'h1, 32'h1);
        drive0(1'b0, 2'b00, 2'b11, 32'h2, 32'h2);
        drive0(1'b0, 2'b00, 2'b01, 32'h3, 32'h0);
        drive0(1'b0, 2'b01, 2'b00, 32'h0, 32'h0);
        chk("cnt.drain_busy", {31'b0, if0.busy}, 32'd1);
        chk("cnt.drain_mm",   {31'b0, if0.mismatch}, 32'd0);
        drive0(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        chk("cnt.mismatch", {31'b0, if0.mismatch}, 32'd1);
        chk("cnt.mask",     {30'b0, if0.mismatch_mask}, 32'd1);
        chk("cnt.cmp",      {16'b0, if0.compare_count}, 32'd2);
        chk("cnt.finish",   {31'b0, if0.finish}, 32'd1);

        // Watchdog on the MAX_CYCLES=20 instance; a start mid-run must be ignored.
        drive1(1'b1, 2'b00);
        chk("wd.cyc0", {16'b0, if1.cycle_count}, 32'd0);
        for (int k = 1; k <= 19; k++) begin
            drive1(k == 10, 2'b00);
            chk($sformatf("wd.cyc%0d", k), {16'b0, if1.cycle_count}, k);
            chk($sformatf("wd.busy%0d", k), {31'b0, if1.busy}, 32'd1);
        end
        drive1(1'b0, 2'b00);
        chk("wd.timeout", {31'b0, if1.timeout}, 32'd1);
        chk("wd.busy",    {31'b0, if1.busy}, 32'd0);
        chk("wd.cyc",     {16'b0, if1.cycle_count}, 32'd19);
        chk("wd.finish",  {31'b0, if1.finish}, 32'd1);

        // STOP_ALL: core 0 stops during cycle 5, core 1 during cycle 9.
        drive1(1'b1, 2'b00);
        chk("sa.cyc0", {16'b0, if1.cycle_count}, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            drive1(1'b0, (k == 6) ? 2'b01 : ((k == 10) ? 2'b10 : 2'b00));
            chk($sformatf("sa.done%0d", k), {31'b0, if1.done}, 32'd0);
            chk($sformatf("sa.busy%0d", k), {31'b0, if1.busy}, 32'd1);
        end
        drive1(1'b0, 2'b00);
        chk("sa.done",   {31'b0, if1.done}, 32'd1);
        chk("sa.cyc",    {16'b0, if1.cycle_count}, 32'd10);
        chk("sa.finish", {31'b0, if1.finish}, 32'd1);

        // Reset mid-RUN aborts with no finish pulse; a fresh run then completes cleanly.
        drive0(1'b1, 2'b00, 2'b00, 32'h0, 32'h0);
        drive0(1'b0, 2'b00, 2'b11, 32'h1, 32'h1);
        drive0(1'b0, 2'b00, 2'b01, 32'h2, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("mr.busy",   {31'b0, if0.busy}, 32'd0);
        chk("mr.cyc",    {16'b0, if0.cycle_count}, 32'd0);
        chk("mr.cmp",    {16'b0, if0.compare_count}, 32'd0);
        chk("mr.finish", {31'b0, if0.finish}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mr.finish_hold%0d", k), {31'b0, if0.finish}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        drive0(1'b1, 2'b00, 2'b00, 32'h0, 32'h0);
        drive0(1'b0, 2'b00, 2'b11, 32'h5, 32'h5);
        drive0(1'b0, 2'b01, 2'b00, 32'h0, 32'h0);
        drive0(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        chk("mr.done",     {31'b0, if0.done}, 32'd1);
        chk("mr.done_cmp", {16'b0, if0.compare_count}, 32'd1);
        chk("mr.done_fin", {31'b0, if0.finish}, 32'd1);
        chk("mr.done_mm",  {31'b0, if0.mismatch}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
